// File: rtl/spin_commit_if.sv
// Candidate/result bundle for spin_commit_checker. The master drives the candidate and the
// slave returns the verdict.
interface spin_commit_if;
   logic             req;
   logic [7:0][7:0]  candActive;
   logic [7:0][7:0]  candOff;
   logic [4:0]       candSpin;
   logic [7:0][7:0]  curActive;
   logic [4:0]       curSpin;
   logic [7:0][7:0]  fixedMatrix;
   logic             busy;
   logic             done;
   logic             accepted;
   logic [7:0][7:0]  activeMatrixOut;
   logic [4:0]       spinOut;
   logic [2:0]       hitRow;
   logic [1:0]       kickDir;

   modport master (
      output req, candActive, candOff, candSpin, curActive, curSpin, fixedMatrix,
      input  busy, done, accepted, activeMatrixOut, spinOut, hitRow, kickDir
   );

   modport slave (
      input  req, candActive, candOff, candSpin, curActive, curSpin, fixedMatrix,
      output busy, done, accepted, activeMatrixOut, spinOut, hitRow, kickDir
   );
endinterface

// File: rtl/spin_commit_checker.sv
// Row-serial collision check of a spun piece against the settled matrix; commits or reverts.
// Optional wall kicks (one column left, then right) are enabled with WALL_KICK_EN.
module spin_commit_checker (
   input  logic         clk,
   input  logic         reset,
   spin_commit_if.slave bus
);

`ifdef WALL_KICK_EN
   typedef enum logic [2:0] {StIdle, StScan, StDecide, StKickL, StKickR} state_e;
`else
   typedef enum logic [1:0] {StIdle, StScan, StDecide} state_e;
`endif

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            hit_q, hit_d;
   logic [2:0]      hit_row_q, hit_row_d;
   logic [7:0][7:0] cand_q, cand_d, off_q, off_d, fixed_q, fixed_d, cur_q, cur_d;
   logic [4:0]      cand_spin_q, cand_spin_d, cur_spin_q, cur_spin_d;
   logic            done_q, done_d, acc_q, acc_d;
   logic [7:0][7:0] mat_q, mat_d;
   logic [4:0]      spin_out_q, spin_out_d;
   logic [2:0]      hit_out_q, hit_out_d;
   logic [7:0][7:0] att_mat;
   logic [7:0]      cand_row, att_row;
   logic            lost_bit, row_viol, retry;
`ifdef WALL_KICK_EN
   logic [1:0]      kick_q, kick_d, kick_out_q, kick_out_d;
`endif

   // Current attempt's row: a bit pushed past the board edge counts as a violation.
   always_comb begin
      cand_row = cand_q[cnt_q];
      att_row  = cand_row;
      lost_bit = 1'b0;
`ifdef WALL_KICK_EN
      case (kick_q)
         2'b01: begin att_row = cand_row >> 1; lost_bit = cand_row[0]; end
         2'b10: begin att_row = cand_row << 1; lost_bit = cand_row[7]; end
         default: ;
      endcase
`endif
      row_viol = (|(att_row & fixed_q[cnt_q])) | (|off_q[cnt_q]) | lost_bit;
   end

   always_comb begin
      att_mat = cand_q;
`ifdef WALL_KICK_EN
      for (int r = 0; r < 8; r++) begin
         case (kick_q)
            2'b01:   att_mat[r] = cand_q[r] >> 1;
            2'b10:   att_mat[r] = cand_q[r] << 1;
            default: att_mat[r] = cand_q[r];
         endcase
      end
      retry = hit_q && (kick_q != 2'b10);
`else
      retry = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hit_d       = hit_q;
      hit_row_d   = hit_row_q;
      cand_d      = cand_q;
      off_d       = off_q;
      fixed_d     = fixed_q;
      cur_d       = cur_q;
      cand_spin_d = cand_spin_q;
      cur_spin_d  = cur_spin_q;
      done_d      = 1'b0;
      acc_d       = acc_q;
      mat_d       = mat_q;
      spin_out_d  = spin_out_q;
      hit_out_d   = hit_out_q;
`ifdef WALL_KICK_EN
      kick_d      = kick_q;
      kick_out_d  = kick_out_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.req) begin
               cand_d      = bus.candActive;
               off_d       = bus.candOff;
               fixed_d     = bus.fixedMatrix;
               cur_d       = bus.curActive;
               cand_spin_d = bus.candSpin;
               cur_spin_d  = bus.curSpin;
               hit_d       = 1'b0;
               hit_row_d   = 3'd0;
               cnt_d       = 3'd0;
               state_d     = StScan;
`ifdef WALL_KICK_EN
               kick_d      = 2'b00;
`endif
            end
         end
`ifdef WALL_KICK_EN
         StScan, StKickL, StKickR: begin
`else
         StScan: begin
`endif
            if (row_viol && !hit_q) begin
               hit_d     = 1'b1;
               hit_row_d = cnt_q;
            end
            if (cnt_q == 3'd7) state_d = StDecide;
            else               cnt_d   = cnt_q + 3'd1;
         end
         StDecide: begin
            if (retry) begin
`ifdef WALL_KICK_EN
               state_d   = (kick_q == 2'b00) ? StKickL : StKickR;
               kick_d    = (kick_q == 2'b00) ? 2'b01 : 2'b10;
               cnt_d     = 3'd0;
               hit_d     = 1'b0;
               hit_row_d = 3'd0;
`endif
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
               // An empty piece is never committed, even with no collision.
               if (!hit_q && (cand_q != '0)) begin
                  acc_d      = 1'b1;
                  mat_d      = att_mat;
                  spin_out_d = cand_spin_q;
                  hit_out_d  = 3'd0;
`ifdef WALL_KICK_EN
                  kick_out_d = kick_q;
`endif
               end else begin
                  acc_d      = 1'b0;
                  mat_d      = cur_q;
                  spin_out_d = cur_spin_q;
                  hit_out_d  = hit_row_q;
`ifdef WALL_KICK_EN
                  kick_out_d = 2'b00;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         hit_q       <= 1'b0;
         hit_row_q   <= 3'd0;
         cand_q      <= '0;
         off_q       <= '0;
         fixed_q     <= '0;
         cur_q       <= '0;
         cand_spin_q <= 5'd0;
         cur_spin_q  <= 5'd0;
         done_q      <= 1'b0;
         acc_q       <= 1'b0;
         mat_q       <= '0;
         spin_out_q  <= 5'd0;
         hit_out_q   <= 3'd0;
`ifdef WALL_KICK_EN
         kick_q      <= 2'b00;
         kick_out_q  <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         hit_row_q   <= hit_row_d;
         cand_q      <= cand_d;
         off_q       <= off_d;
         fixed_q     <= fixed_d;
         cur_q       <= cur_d;
         cand_spin_q <= cand_spin_d;
         cur_spin_q  <= cur_spin_d;
         done_q      <= done_d;
         acc_q       <= acc_d;
         mat_q       <= mat_d;
         spin_out_q  <= spin_out_d;
         hit_out_q   <= hit_out_d;
`ifdef WALL_KICK_EN
         kick_q      <= kick_d;
         kick_out_q  <= kick_out_d;
`endif
      end
   end

   assign bus.busy            = (state_q != StIdle);
   assign bus.done            = done_q;
   assign bus.accepted        = acc_q;
   assign bus.activeMatrixOut = mat_q;
   assign bus.spinOut         = spin_out_q;
   assign bus.hitRow          = hit_out_q;
`ifdef WALL_KICK_EN
   assign bus.kickDir         = kick_out_q;
`else
   assign bus.kickDir         = 2'b00;
`endif

endmodule

// File: tb/tb_spin_commit_checker.sv
// Bench for spin_commit_checker: directed scenarios plus random candidates checked against
// an attempt-by-attempt reference model.
module tb_spin_commit_checker;
   logic clk;
   logic reset;
   spin_commit_if bus ();

   spin_commit_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0][7:0] t_cand, t_off, t_fixed, t_cur;
   logic [4:0]      t_cspin, t_curspin;
   logic            e_acc;
   logic [7:0][7:0] e_mat;
   logic [4:0]      e_spin;
   logic [2:0]      e_hit;
   logic [1:0]      e_kick;
   int              e_lat;

   function automatic logic [74:0] obs_vec();
      return {bus.accepted, bus.spinOut, bus.hitRow, bus.kickDir, bus.activeMatrixOut};
   endfunction

   function automatic logic [74:0] exp_vec();
      return {e_acc, e_spin, e_hit, e_kick, e_mat};
   endfunction

   // Tries the unshifted piece, then (with kicks) one column left, then one right.
   task automatic model();
      int n_att, first, row, sh, lost;
      logic [7:0][7:0] m;
`ifdef WALL_KICK_EN
      n_att = 3;
`else
      n_att = 1;
`endif
      e_acc = 1'b0; e_hit = 3'd0; e_kick = 2'd0; e_lat = 0;
      e_mat = t_cur; e_spin = t_curspin;
      for (int a = 0; a < n_att; a++) begin
         e_lat += 9;
         first = -1;
         for (int r = 0; r < 8; r++) begin
            row = int'(t_cand[r]);
            case (a)
               0:       begin sh = row;             lost = 0;                  end
               1:       begin sh = row / 2;         lost = row % 2;            end
               default: begin sh = (row * 2) % 256; lost = (row >= 128) ? 1 : 0; end
            endcase
            m[r] = 8'(sh);
            if ((((sh & int'(t_fixed[r])) != 0) || (t_off[r] != 8'd0) || (lost != 0)) &&
                (first < 0))
               first = r;
         end
         if (first < 0) begin
            e_hit = 3'd0;
            if (t_cand != '0) begin
               e_acc = 1'b1; e_mat = m; e_spin = t_cspin; e_kick = 2'(a);
            end
            break;
         end
         e_hit = 3'(first);
      end
   endtask

   task automatic apply();
      bus.candActive  = t_cand;
      bus.candOff     = t_off;
      bus.fixedMatrix = t_fixed;
      bus.curActive   = t_cur;
      bus.candSpin    = t_cspin;
      bus.curSpin     = t_curspin;
   endtask

   task automatic base_piece();
      t_cand = '0; t_off = '0; t_fixed = '0; t_cur = '0;
      t_cand[1] = 8'h18; t_cand[2] = 8'h18;
      t_cur[0] = 8'h03; t_cur[1] = 8'h01;
      t_cspin = 5'd9; t_curspin = 5'd4;
   endtask

   // Pulses req for edge E0 and returns the edge index of done (-1 if it never came).
   task automatic run_one(output int edges);
      apply();
      @(negedge clk); bus.req = 1'b1;
      @(posedge clk); #1 bus.req = 1'b0;
      edges = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin edges = n; break; end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({bus.busy, bus.done, obs_vec()} !== 77'd0) begin
         errors++;
         $display("FAIL reset_state got %h want 0", {bus.busy, bus.done, obs_vec()});
      end
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle got %b want 00", {bus.busy, bus.done});
      end
   endtask

   task automatic test_accept();
      int lat;
      base_piece(); model(); run_one(lat);
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL accept_latency got %0d want 9", lat); end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL accept_result got %h want %h", obs_vec(), exp_vec());
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL accept_done_pulse got 1 want 0"); end
   endtask

   task automatic test_reject_overlap();
      int lat;
      base_piece(); t_fixed[2] = 8'h08; model(); run_one(lat);
      checks++;
      if (lat !== e_lat) begin
         errors++; $display("FAIL overlap_latency got %0d want %0d", lat, e_lat);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL overlap_result got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_off_board();
      int lat;
      base_piece(); t_off[5] = 8'h01; model(); run_one(lat);
      checks++;
      if (lat !== e_lat) begin
         errors++; $display("FAIL offboard_latency got %0d want %0d", lat, e_lat);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL offboard_result got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_empty();
      int lat;
      base_piece(); t_cand = '0; model(); run_one(lat);
      checks++;
      if ({lat, obs_vec()} !== {e_lat, exp_vec()}) begin
         errors++;
         $display("FAIL empty_piece got %0d/%h want %0d/%h", lat, obs_vec(), e_lat, exp_vec());
      end
   endtask

`ifdef WALL_KICK_EN
   task automatic test_kick();
      int lat;
      base_piece(); t_fixed[1] = 8'h10; model(); run_one(lat);
      checks++;
      if ({lat, bus.accepted, bus.kickDir, bus.activeMatrixOut[1], bus.activeMatrixOut[2]} !==
          {32'd18, 1'b1, 2'b01, 8'h0C, 8'h0C}) begin
         errors++;
         $display("FAIL kick_left got lat %0d acc %b kick %b rows %h %h", lat, bus.accepted,
                  bus.kickDir, bus.activeMatrixOut[1], bus.activeMatrixOut[2]);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL kick_result got %h want %h", obs_vec(), exp_vec());
      end
   endtask
`endif

   task automatic test_hold();
      bus.candActive  = {$urandom, $urandom};
      bus.fixedMatrix = {$urandom, $urandom};
      bus.curActive   = {$urandom, $urandom};
      bus.curSpin     = 5'($urandom);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, obs_vec()} !== {2'b00, exp_vec()}) begin
         errors++;
         $display("FAIL hold_outputs got %h want %h", {bus.busy, bus.done, obs_vec()},
                  {2'b00, exp_vec()});
      end
   endtask

   task automatic test_busy_ignore();
      int dones, edge_at;
      logic [74:0] got;
      base_piece(); t_fixed[2] = 8'h08; model(); apply();
      @(negedge clk); bus.req = 1'b1;
      @(posedge clk); #1 bus.req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_high got %b want 1", bus.busy); end
      bus.req = 1'b1;
      bus.candActive = '0; bus.fixedMatrix = '1; bus.curSpin = 5'd31;
      dones = 0; edge_at = -1; got = '0;
      for (int n = 3; n <= 45; n++) begin
         @(posedge clk); #1;
         if (n == 3) bus.req = 1'b0;
         if (bus.done === 1'b1) begin
            dones++;
            if (edge_at < 0) begin edge_at = n; got = obs_vec(); end
         end
      end
      checks++;
      if ({dones, edge_at} !== {32'd1, e_lat}) begin
         errors++;
         $display("FAIL busy_ignore got %0d dones at %0d want 1 at %0d", dones, edge_at, e_lat);
      end
      checks++;
      if (got !== exp_vec()) begin
         errors++; $display("FAIL busy_snapshot got %h want %h", got, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      base_piece(); model(); apply();
      n1 = -1; n2 = -1;
      @(negedge clk); bus.req = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            if (n1 < 0) n1 = n;
            else begin n2 = n; bus.req = 1'b0; break; end
         end
      end
      bus.req = 1'b0;
      checks++;
      if ({n1, n2} !== {e_lat, 2 * e_lat + 1}) begin
         errors++;
         $display("FAIL back_to_back got %0d,%0d want %0d,%0d", n1, n2, e_lat, 2 * e_lat + 1);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int dones, lat;
      base_piece(); model(); apply();
      @(negedge clk); bus.req = 1'b1;
      @(posedge clk); #1 bus.req = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, obs_vec()} !== 77'd0) begin
         errors++;
         $display("FAIL reset_mid_clear got %h want 0", {bus.busy, bus.done, obs_vec()});
      end
      dones = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL reset_mid_done got %0d want 0", dones); end
      @(posedge clk); #2 reset = 1'b1;
      run_one(lat);
      checks++;
      if ({lat, obs_vec()} !== {e_lat, exp_vec()}) begin
         errors++;
         $display("FAIL reset_recover got %0d/%h want %0d/%h", lat, obs_vec(), e_lat, exp_vec());
      end
   endtask

   task automatic test_random();
      int lat;
      for (int i = 0; i < 40; i++) begin
         t_cand = '0; t_off = '0; t_fixed = '0;
         for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) t_cand[r] = 8'($urandom & $urandom);
            if ($urandom_range(0, 1) == 0) t_fixed[r] = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 30) == 0) t_off[r] = 8'd1 << $urandom_range(0, 7);
         end
         t_cur = {$urandom, $urandom};
         t_cspin = 5'($urandom); t_curspin = 5'($urandom);
         model(); run_one(lat);
         checks++;
         if ({lat, obs_vec()} !== {e_lat, exp_vec()}) begin
            errors++;
            $display("FAIL random_%0d got %0d/%h want %0d/%h", i, lat, obs_vec(), e_lat,
                     exp_vec());
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.req = 1'b0;
      base_piece(); apply();
      test_reset();
      test_accept();
      test_reject_overlap();
      test_off_board();
      test_empty();
`ifdef WALL_KICK_EN
      test_kick();
`endif
      test_hold();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
